// File: rtl/float_to_fixed_serial_pkg.sv
// Shared types and constants for the float-to-fixed conversion path.
package float_fixed_pkg;

  localparam int FP_BIAS  = 127;
  localparam int FP_MAN_W = 23;
  localparam int FP_EXP_W = 8;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DONE  = 2'd2
  } ftf_state_e;

  // Outcome class decided at acceptance; SP_MIN is the one exact -2^31 case.
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_ZERO = 2'd1,
    SP_SAT  = 2'd2,
    SP_MIN  = 2'd3
  } special_e;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  function automatic logic [31:0] sat_value(input logic sign);
    return sign ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/float_to_fixed_serial_if.sv
// Valid/ready bundle: float + fractional-bit count in, fixed-point word + overflow flag out.
interface float_to_fixed_serial_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_float;
  logic [4:0]        fixpointpos;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              ovf;

  modport master (
    output in_valid, in_float, fixpointpos, out_ready,
    input  in_ready, out_valid, result, ovf
  );

  modport slave (
    input  in_valid, in_float, fixpointpos, out_ready,
    output in_ready, out_valid, result, ovf
  );
endinterface

// File: rtl/float_to_fixed_serial_align_shifter.sv
// ftf_align_shifter: magnitude/count register slice, shifts one bit per enabled cycle.
// With FTF_ROUND_NEAREST_EN, tracks guard/sticky and presents the round-half-even magnitude.
module ftf_align_shifter
  import float_fixed_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic              i_left,
  input  logic [DATA_W-1:0] i_mag,
  input  logic [4:0]        i_cnt,
  output logic [DATA_W-1:0] o_mag,
  output logic              o_cnt_zero
);

  logic [DATA_W-1:0] r_mag;
  logic [4:0]        r_cnt;
  logic              r_left;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mag  <= '0;
      r_cnt  <= '0;
      r_left <= 1'b0;
    end else if (i_load) begin
      r_mag  <= i_mag;
      r_cnt  <= i_cnt;
      r_left <= i_left;
    end else if (i_shift) begin
      r_mag  <= r_left ? {r_mag[DATA_W-2:0], 1'b0} : {1'b0, r_mag[DATA_W-1:1]};
      r_cnt  <= r_cnt - 5'd1;
    end
  end

  assign o_cnt_zero = (r_cnt == '0);

`ifdef FTF_ROUND_NEAREST_EN
  logic r_guard;
  logic r_sticky;
  logic w_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
    end else if (i_load) begin
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
    end else if (i_shift && !r_left) begin
      r_sticky <= r_sticky | r_guard;
      r_guard  <= r_mag[0];
    end
  end

  // Cannot carry out: after any right shift the magnitude is below 2^24.
  assign w_inc = r_guard & (r_sticky | r_mag[0]);
  assign o_mag = r_mag + {{(DATA_W-1){1'b0}}, w_inc};
`else
  assign o_mag = r_mag;
`endif

endmodule

// File: rtl/float_to_fixed_serial.sv
// IEEE single to signed fixed-point, one alignment bit per clock; out_valid N+1 cycles after accept.
// One conversion in flight, result held in DONE until out_ready; FTF_ROUND_NEAREST_EN adds round-half-even.
module float_to_fixed_serial
  import float_fixed_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MAX_RSHIFT = 25
) (
  input  logic                     clk,
  input  logic                     rst,
  float_to_fixed_serial_if.slave   bus
);

  localparam logic signed [9:0] RSH_CLAMP = 10'(MAX_RSHIFT);

  ftf_state_e        r_state;
  special_e          r_special;
  logic              r_sign;
  logic [DATA_W-1:0] r_result;
  logic              r_ovf;

  fp32_t             w_fp;
  special_e          w_special;
  logic signed [9:0] w_p;
  logic signed [9:0] w_rsh;
  logic              w_left;
  logic              w_accept;
  logic              w_shift;
  logic              w_cnt_zero;
  logic [4:0]        w_cnt;
  logic [DATA_W-1:0] w_mag_load;
  logic [DATA_W-1:0] w_mag;
  logic [DATA_W-1:0] w_result;
  logic              w_ovf;

  assign w_fp     = fp32_t'(bus.in_float);
  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_p      = $signed({2'b00, w_fp.exp}) + $signed({5'b00000, bus.fixpointpos}) - 10'sd127;
  assign w_rsh    = 10'sd23 - w_p;
  assign w_left   = (w_p > 10'sd23);
  assign w_mag_load = {{(DATA_W-FP_MAN_W-1){1'b0}}, 1'b1, w_fp.man};

  always_comb begin
    w_special = SP_NONE;
    if (w_fp.exp == '0)
      w_special = SP_ZERO;
    else if (w_fp.exp == '1)
      w_special = SP_SAT;
    else if (w_p >= 10'sd31)
      w_special = (w_fp.sign && (w_p == 10'sd31) && (w_fp.man == '0)) ? SP_MIN : SP_SAT;
  end

  // Specials finish on the first ALIGN edge; right shifts past the clamp only feed sticky.
  always_comb begin
    w_cnt = '0;
    if (w_special == SP_NONE) begin
      if (w_left)
        w_cnt = 5'(w_p - 10'sd23);
      else if (w_rsh > RSH_CLAMP)
        w_cnt = 5'(MAX_RSHIFT);
      else
        w_cnt = 5'(w_rsh);
    end
  end

  assign w_shift = (r_state == ALIGN) && !w_cnt_zero;

  ftf_align_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_shift    (w_shift),
    .i_left     (w_left),
    .i_mag      (w_mag_load),
    .i_cnt      (w_cnt),
    .o_mag      (w_mag),
    .o_cnt_zero (w_cnt_zero)
  );

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (r_special)
      SP_ZERO: w_result = '0;
      SP_SAT: begin
        w_result = sat_value(r_sign);
        w_ovf    = 1'b1;
      end
      SP_MIN:  w_result = SAT_NEG;
      default: w_result = r_sign ? (~w_mag + 1'b1) : w_mag;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_special <= SP_NONE;
      r_sign    <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_state   <= ALIGN;
          r_sign    <= w_fp.sign;
          r_special <= w_special;
        end
        ALIGN: if (w_cnt_zero) begin
          r_state  <= DONE;
          r_result <= w_result;
          r_ovf    <= w_ovf;
        end
        DONE: if (bus.out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_float_to_fixed_serial.sv
// Bench for float_to_fixed_serial: arithmetic reference model, per-cycle output compare, directed + random stimulus.
module tb_float_to_fixed_serial;
  import float_fixed_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  float_to_fixed_serial_if #(.DATA_W(32)) bus ();

  float_to_fixed_serial #(
    .DATA_W     (32),
    .MAX_RSHIFT (25)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          lat;
    time         t_acc;
  } xact_t;

  xact_t exp_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    rdy_mode = 0;

`ifdef FTF_ROUND_NEAREST_EN
  localparam logic [31:0] RES_1P5 = 32'd2;
`else
  localparam logic [31:0] RES_1P5 = 32'd1;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  // Reference: value = 1.man * 2^(exp-127) * 2^fp, truncated (or rounded half-even), then clipped.
  function automatic xact_t model(input logic [31:0] f, input logic [4:0] fp);
    xact_t            e;
    int               ex, p, s, rs;
    logic             sg;
    longint unsigned  m, v, rem, half, lim;
    sg = f[31];
    ex = int'(f[30:23]);
    m  = {40'd0, 1'b1, f[22:0]};
    p  = ex - 127 + int'(fp);
    s  = p - 23;
    e.t_acc = 0;
    e.ovf   = 1'b0;
    e.res   = 32'd0;
    if (ex == 0 || ex == 255 || p >= 31) e.lat = 1;
    else if (s >= 0)                     e.lat = 1 + s;
    else                                 e.lat = 1 + ((-s > 25) ? 25 : -s);
    if (ex == 0) return e;
    if (ex == 255) begin
      e.res = sg ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.ovf = 1'b1;
      return e;
    end
    if (s >= 0) begin
      v = (s > 20) ? 64'h10_0000_0000 : (m << s);
    end else begin
      rs = -s;
      if (rs >= 40) v = 64'd0;
      else begin
        v = m >> rs;
`ifdef FTF_ROUND_NEAREST_EN
        rem  = m & ((64'd1 << rs) - 64'd1);
        half = 64'd1 << (rs - 1);
        if (rem > half || (rem == half && v[0])) v = v + 64'd1;
`endif
      end
    end
    lim = sg ? 64'h8000_0000 : 64'h7FFF_FFFF;
    if (v > lim) begin
      e.res = sg ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.ovf = 1'b1;
    end else begin
      e.res = sg ? (32'd0 - v[31:0]) : v[31:0];
    end
    return e;
  endfunction

  task automatic send(input logic [31:0] f, input logic [4:0] fp);
    int    k = 0;
    xact_t e;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_float    = f;
    bus.fixpointpos = fp;
    while (!bus.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) begin
      n_chk++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, k);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e = model(f, fp);
    e.t_acc = $time;
    exp_q.push_back(e);
    #1;
    bus.in_valid    = 1'b0;
    bus.in_float    = $urandom;
    bus.fixpointpos = 5'($urandom);
  endtask

  task automatic directed(input logic [31:0] f, input logic [4:0] fp,
                          input logic [31:0] res, input logic ovf, input int lat);
    xact_t m;
    m = model(f, fp);
    chk($sformatf("model_res_%h_fp%0d", f, fp), m.res, res);
    chk($sformatf("model_ovf_%h_fp%0d", f, fp), 32'(m.ovf), 32'(ovf));
    chk($sformatf("model_lat_%h_fp%0d", f, fp), 32'(m.lat), 32'(lat));
    send(f, fp);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
  endtask

  // Downstream ready: 0 = always, 1 = random, 2 = held low.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Output compare: first DONE cycle vs model, later DONE cycles vs held value.
  initial begin
    logic        seen, prev_hs, held_ovf;
    logic [31:0] held_res;
    xact_t       e;
    int          lat;
    seen = 1'b0;
    prev_hs = 1'b0;
    held_res = '0;
    held_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) begin
          chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
          chk("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
        end
        prev_hs = 1'b0;
        if (bus.out_valid) begin
          chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
          if (!seen) begin
            if (exp_q.size() == 0) begin
              n_chk++;
              $display("FAIL unexpected_output: result %h with nothing pending, required no out_valid", bus.result);
            end else begin
              e = exp_q[0];
              lat = int'(($time - e.t_acc - 5) / 10);
              chk("result", bus.result, e.res);
              chk("ovf", 32'(bus.ovf), 32'(e.ovf));
              chk("latency", 32'(lat), 32'(e.lat));
            end
            seen = 1'b1;
            held_res = bus.result;
            held_ovf = bus.ovf;
          end else begin
            chk("result_hold", bus.result, held_res);
            chk("ovf_hold", 32'(bus.ovf), 32'(held_ovf));
          end
          if (bus.out_ready) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            seen = 1'b0;
            prev_hs = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int          k;
    logic [31:0] f;
    logic [7:0]  ex;
    bus.in_valid    = 1'b0;
    bus.in_float    = '0;
    bus.fixpointpos = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    directed(32'h41CA_0000, 5'd2,  32'h0000_0065, 1'b0, 18);
    directed(32'hC1CA_0000, 5'd2,  32'hFFFF_FF9B, 1'b0, 18);
    directed(32'h4700_0000, 5'd10, 32'h0200_0000, 1'b0, 3);
    directed(32'h0000_0000, 5'd17, 32'h0000_0000, 1'b0, 1);
    directed(32'h8000_0000, 5'd5,  32'h0000_0000, 1'b0, 1);
    directed(32'h7F80_0000, 5'd0,  32'h7FFF_FFFF, 1'b1, 1);
    directed(32'hFF80_0000, 5'd3,  32'h8000_0000, 1'b1, 1);
    directed(32'h4F00_0000, 5'd0,  32'h7FFF_FFFF, 1'b1, 1);
    directed(32'hCF00_0000, 5'd0,  32'h8000_0000, 1'b0, 1);
    directed(32'h3FC0_0000, 5'd0,  RES_1P5,       1'b0, 24);
    directed(32'h4020_0000, 5'd0,  32'h0000_0002, 1'b0, 23);
    drain();

    // Backpressure, then a back-to-back input right after release.
    rdy_mode = 2;
    send(32'h41CA_0000, 5'd2);
    k = 0;
    while (!bus.out_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (5) @(negedge clk);
    rdy_mode = 0;
    send(32'h4700_0000, 5'd10);
    drain();

    // Reset in the middle of a 23-step alignment.
    send(32'h3F80_0000, 5'd0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    chk("midrst_ovf", 32'(bus.ovf), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    send(32'hC1CA_0000, 5'd2);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case ($urandom_range(0, 9))
        0:       ex = 8'd0;
        1:       ex = 8'd255;
        default: ex = 8'($urandom_range(96, 160));
      endcase
      f = $urandom;
      f[30:23] = ex;
      if ($urandom_range(0, 5) == 0) f[22:0] = '0;
      send(f, 5'($urandom));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/float_to_fixed_serial.md
Name: float_to_fixed_serial

Overview:
- Iterative IEEE-754 single-precision to signed two's-complement fixed-point converter.
- Sits directly downstream of the fixed-to-float stage: consumes its 32-bit float result and a fractional-bit count, and produces a 32-bit fixed-point word.
- Aligns the significand one bit position per clock; valid/ready handshake on both sides.
- Result is truncated toward zero by default; optional round-to-nearest-even.

Parameters:
- DATA_W, 32, float input and fixed output width (only 32 supported).
- MAX_RSHIFT, 25, clamp on right-shift iterations; everything beyond this shifts out to zero/sticky.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- in_valid  in  1  upstream float valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_float  in  32  IEEE single {sign, exp[7:0], man[22:0]}.
- fixpointpos  in  5  number of fractional bits of result, 0..31.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  32  signed fixed-point result.
- ovf  out  1  result saturated (qualified by out_valid).

Behaviour:
- Reset (rst=0, async): state=IDLE; in_ready=1, out_valid=0, result=0, ovf=0; internal regs cleared. Reset mid-conversion aborts silently.
- Acceptance edge k (in_valid & in_ready):
  - sample in_float and fixpointpos;
  - compute E = exp-127, P = E+fixpointpos (signed 10-bit);
  - load mag = {1,man} zero-extended to 32 bits; go to ALIGN.
- Special cases at acceptance (count N=0, mag preloaded):
  - exp==0 (zero/denormal) -> 0, ovf=0.
  - exp==255 (Inf/NaN) -> saturate by sign, ovf=1.
  - P>=31 -> saturate, ovf=1. Exception: sign=1, P==31, man==0 gives 0x80000000 with ovf=0.
- Saturation values: 0x7FFFFFFF positive, 0x80000000 negative.
- Normal case:
  - P>23: left-shift count N=P-23 (<=7).
  - P<=23: right-shift count N=min(23-P, MAX_RSHIFT).
  - Right shifts collect guard and sticky bits.
- ALIGN state:
  - each edge with N!=0 shifts mag one bit in the fixed direction and decrements N;
  - the edge with N==0 applies optional rounding, negates if sign=1, writes result/ovf and goes to DONE.
- Latency: out_valid rises after edge k+N+1. Minimum 1, maximum 26 cycles.
- DONE state:
  - out_valid=1; result/ovf held stable while out_ready=0;
  - on out_valid & out_ready -> IDLE; in_ready=1 the next cycle.
  - No overlap: one conversion in flight.
- in_float and fixpointpos are ignored outside the acceptance edge.
- Result is truncated toward zero in magnitude, then the sign is applied.

Optional Feature:
- Macro: FTF_ROUND_NEAREST_EN.
- Defined: at the final ALIGN edge of a right-shifted conversion, mag += guard & (sticky | mag[0]) (round half to even) before negation. The increment cannot overflow because mag < 2^24 after any right shift.
- Undefined: guard/sticky logic is absent and results truncate toward zero.

Decomposition:
- Shared package float_fixed_pkg:
  - state enum (IDLE, ALIGN, DONE);
  - constants FP_BIAS=127, FP_MAN_W=23, FP_EXP_W=8;
  - saturation constants SAT_POS and SAT_NEG;
  - typedef for the float field struct.
- One natural sub-module: ftf_align_shifter, holding the mag/count/guard/sticky register slice. The FSM and handshake stay in the top.

Test Plan:
- 0x41CA0000 (25.25), fp=2 -> result 0x00000065, ovf=0, out_valid 18 cycles after acceptance (N=17).
- 0xC1CA0000, fp=2 -> 0xFFFFFF9B. Also 0x47000000 (32768), fp=10 -> 0x02000000, latency 3.
- 0x00000000 and 0x80000000, any fp -> 0x00000000, ovf=0, latency 1. 0x7F800000 -> 0x7FFFFFFF, ovf=1.
- 0x4F000000, fp=0 -> 0x7FFFFFFF, ovf=1. 0xCF000000, fp=0 -> 0x80000000, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0. Release -> handshake, then in_ready=1 next cycle and a back-to-back input is accepted.
- Reset asserted mid-ALIGN -> out_valid=0, result=0 immediately; in_ready=1 after release.
- Rounding: 0x3FC00000 (1.5), fp=0 -> 1 without macro, 2 with FTF_ROUND_NEAREST_EN. 0x40200000 (2.5) -> 2 in both builds.
